weight_loader: RTL

Weight-tile loader that drives the write side of `weightFifo` and the `wwrite` strobe of `sysArr`. On a `start` request it fetches one `width_height`-row weight tile from the weight memory, pushes the rows into the FIFO in address order, then drives the latch phase that commits the shifted weights into the systolic array. It replaces the hand-sequenced `en`/`weightIn`/`wwrite` stimulus in the TPU datapath and reports completion to the top-level controller.

---
 rtl/weight_loader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/weight_loader.sv
// Weight-tile loader: reads one N-row tile from weight memory, shifts it into
// the weight FIFO, then strobes wwrite for N cycles to latch it into the array.
module weight_loader #(
   parameter  int DATA_WIDTH   = 8,
   parameter  int FIFO_INPUTS  = 4,
   parameter  int FIFO_STAGES  = 4,
   parameter  int width_height = 4,
   parameter  int ADDR_WIDTH   = 8,
   localparam int FIFO_WIDTH   = DATA_WIDTH * FIFO_INPUTS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   base_addr,
   output logic                    busy,
   output logic                    done,
   output logic                    mem_rd_en,
   output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
   input  logic [FIFO_WIDTH-1:0]   mem_rd_data,
   output logic                    fifo_en,
   output logic [FIFO_WIDTH-1:0]   weightIn,
   output logic [width_height-1:0] wwrite
);

   localparam int             CNT_W = $clog2(width_height) + 1;
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(width_height - 1);

   generate
      if (FIFO_STAGES != width_height || FIFO_INPUTS != width_height) begin : g_cfg_check
         $error("weight_loader: FIFO_STAGES and FIFO_INPUTS must equal width_height");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_LATCH,
      S_DONE
   } state_t;

   state_t                state, nxt_state;
   logic [CNT_W-1:0]      row_cnt, nxt_cnt;
   logic [ADDR_WIDTH-1:0] base_q, nxt_base, nxt_addr;

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = row_cnt;
      nxt_base  = base_q;
      nxt_addr  = '0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               nxt_state = S_FETCH;
               nxt_cnt   = '0;
               nxt_base  = base_addr;
            end
         end
         S_FETCH: begin
            if (row_cnt == LAST_ROW) begin
               nxt_state = S_DRAIN;
               nxt_cnt   = '0;
            end else begin
               nxt_cnt = row_cnt + 1'b1;
            end
         end
         S_DRAIN: begin
            nxt_state = S_LATCH;
            nxt_cnt   = '0;
         end
         S_LATCH: begin
            if (row_cnt == LAST_ROW) begin
               nxt_state = S_DONE;
               nxt_cnt   = '0;
            end else begin
               nxt_cnt = row_cnt + 1'b1;
            end
         end
         S_DONE:  nxt_state = S_IDLE;
         default: nxt_state = S_IDLE;
      endcase
      // Address wraps naturally at ADDR_WIDTH bits.
      if (nxt_state == S_FETCH) nxt_addr = nxt_base + ADDR_WIDTH'(nxt_cnt);
   end

   // Outputs are registered from the next state so they line up with the
   // state the FSM is in during the same cycle.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         row_cnt     <= '0;
         base_q      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_rd_addr <= '0;
         fifo_en     <= 1'b0;
         wwrite      <= '0;
      end else begin
         state       <= nxt_state;
         row_cnt     <= nxt_cnt;
         base_q      <= nxt_base;
         busy        <= (nxt_state == S_FETCH) || (nxt_state == S_DRAIN) ||
                        (nxt_state == S_LATCH);
         done        <= (nxt_state == S_DONE);
         mem_rd_en   <= (nxt_state == S_FETCH);
         mem_rd_addr <= nxt_addr;
         // A row is pushed the cycle after its read; LATCH shifts in zeros.
         fifo_en     <= mem_rd_en || (nxt_state == S_LATCH);
         wwrite      <= (nxt_state == S_LATCH) ? '1 : '0;
      end
   end

   assign weightIn = (fifo_en && (state == S_FETCH || state == S_DRAIN)) ? mem_rd_data : '0;

endmodule
